// File: rtl/alu_sequencer.sv
// Instruction FIFO + 8x8 register file that sequences an external 8-bit ALU (READ/EXEC/WB).
// Optional: define NOP_SKIP_EN to retire ops 1101-1111 in READ without touching the ALU.
module alu_sequencer #(
   parameter int DEPTH = 4,
   parameter int NREG  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_op,
   input  logic [2:0] in_rd,
   input  logic [2:0] in_rs1,
   input  logic [2:0] in_rs2,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic [3:0] alu_ctrl,
   output logic [7:0] alu_x,
   output logic [7:0] alu_y,
   input  logic [7:0] alu_out,
   input  logic       alu_carry,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic       res_carry,
   output logic [2:0] res_rd,
   output logic       busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

   typedef struct packed {
      logic [3:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
   } instr_t;

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t        state_q, state_d;
   instr_t        fifo_q [DEPTH];
   instr_t        fifo_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [7:0]    rf_q [NREG];
   logic [7:0]    rf_d [NREG];
   logic [3:0]    alu_ctrl_q, alu_ctrl_d;
   logic [7:0]    alu_x_q, alu_x_d, alu_y_q, alu_y_d;
   logic [2:0]    rd_q, rd_d;
   logic          res_valid_q, res_valid_d;
   logic [7:0]    res_data_q, res_data_d;
   logic          res_carry_q, res_carry_d;
   logic [2:0]    res_rd_q, res_rd_d;

   instr_t in_instr, head;
   logic   full, push, pop, skip_nop;

   assign in_instr = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2};
   assign head     = fifo_q[rd_ptr_q];
   assign full     = (count_q == CNT_FULL);
   assign in_ready = rst_n & ~full;
   assign push     = in_valid & in_ready;
   // READ is only entered with a non-empty FIFO, so it always pops the head.
   assign pop      = (state_q == READ);

`ifdef NOP_SKIP_EN
   assign skip_nop = (head.op > 4'b1100);
`else
   assign skip_nop = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      fifo_d      = fifo_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rf_d        = rf_q;
      alu_ctrl_d  = alu_ctrl_q;
      alu_x_d     = alu_x_q;
      alu_y_d     = alu_y_q;
      rd_d        = rd_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
      res_rd_d    = res_rd_q;
      count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);

      if (push) begin
         fifo_d[wr_ptr_q] = in_instr;
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

      // Write-back is applied after the host write so it wins on an address clash.
      if (wr_en) rf_d[wr_addr] = wr_data;
      if (state_q == WB) rf_d[res_rd_q] = res_data_q;

      case (state_q)
         IDLE: if (count_q != '0) state_d = READ;
         READ: begin
            if (skip_nop) begin
               state_d = (count_d != '0) ? READ : IDLE;
            end else begin
               alu_ctrl_d = head.op;
               alu_x_d    = rf_q[head.rs1];
               alu_y_d    = rf_q[head.rs2];
               rd_d       = head.rd;
               state_d    = EXEC;
            end
         end
         EXEC: begin
            res_data_d  = alu_out;
            res_carry_d = alu_carry;
            res_rd_d    = rd_q;
            res_valid_d = 1'b1;
            state_d     = WB;
         end
         WB:      state_d = (count_q != '0) ? READ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         alu_ctrl_q  <= '0;
         alu_x_q     <= '0;
         alu_y_q     <= '0;
         rd_q        <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_rd_q    <= '0;
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         for (int i = 0; i < NREG; i++)  rf_q[i]   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         alu_ctrl_q  <= alu_ctrl_d;
         alu_x_q     <= alu_x_d;
         alu_y_q     <= alu_y_d;
         rd_q        <= rd_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
         res_rd_q    <= res_rd_d;
         fifo_q      <= fifo_d;
         rf_q        <= rf_d;
      end
   end

   assign alu_ctrl  = alu_ctrl_q;
   assign alu_x     = alu_x_q;
   assign alu_y     = alu_y_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_carry = res_carry_q;
   assign res_rd    = res_rd_q;
   assign busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the external ALU.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_op = '0;
   logic [2:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic [3:0] alu_ctrl;
   logic [7:0] alu_x, alu_y, alu_out;
   logic       alu_carry;
   logic       res_valid, res_carry, busy;
   logic [7:0] res_data;
   logic [2:0] res_rd;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] data;
      logic       carry;
      logic [2:0] rd;
   } res_t;
   res_t q[$];

   alu_sequencer #(.DEPTH(4), .NREG(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
      .alu_out(alu_out), .alu_carry(alu_carry),
      .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
      .res_rd(res_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   // ALU model: sub carry means "no borrow"; codes 1101-1111 return 0.
   always_comb begin
      alu_out   = 8'h00;
      alu_carry = 1'b0;
      case (alu_ctrl)
         4'h0: {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
         4'h1: begin alu_out = alu_x - alu_y; alu_carry = (alu_x >= alu_y); end
         4'h2: alu_out = alu_x & alu_y;
         4'h3: alu_out = alu_x | alu_y;
         4'h4: alu_out = alu_x ^ alu_y;
         4'h5: alu_out = ~alu_x;
         4'h6: {alu_carry, alu_out} = {alu_x, 1'b0};
         4'h7: alu_out = alu_x >> 1;
         4'h8: {alu_carry, alu_out} = {1'b0, alu_x} + 9'd1;
         4'h9: alu_out = alu_x - 8'd1;
         4'hA: alu_out = alu_x;
         4'hB: alu_out = {7'd0, alu_x < alu_y};
         4'hC: alu_out = {7'd0, alu_x == alu_y};
         default: ;
      endcase
   end

   always @(negedge clk) if (rst_n && res_valid) q.push_back('{res_data, res_carry, res_rd});

   task tick;
      @(posedge clk); #1;
   endtask

   task preload(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
      int n;
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL issue_accept: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task wait_res(output logic got, output res_t r);
      got = 1'b0;
      r = '{8'h00, 1'b0, 3'd0};
      for (int i = 0; i < 60; i++) begin
         if (q.size() > 0) begin r = q.pop_front(); got = 1'b1; break; end
         tick();
      end
   endtask

   // Reads a register by routing it through ADD rd=7 rs2=r0 (r0 kept at 0).
   task read_reg(input logic [2:0] a, output logic [7:0] d);
      logic got; res_t r;
      issue(4'h0, 3'd7, a, 3'd0);
      wait_res(got, r);
      d = got ? r.data : 8'hxx;
   endtask

   task test_reset;
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b required 0", res_valid); end
      n_chk++;
      if ({alu_ctrl, alu_x, alu_y, res_data, res_carry, res_rd} !== 32'h0) begin
         n_fail++; $display("FAIL rst_outputs: got %h/%h/%h/%h/%b/%h required all 0",
                            alu_ctrl, alu_x, alu_y, res_data, res_carry, res_rd);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
      tick();
   endtask

   task test_add;
      logic [3:0] rv;
      logic [7:0] d;
      preload(3'd1, 8'h7D);
      preload(3'd2, 8'h07);
      in_valid = 1'b1; in_op = 4'h0; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin @(negedge clk); rv[c] = res_valid; end
      n_chk++; if (rv !== 4'b1000) begin n_fail++; $display("FAIL add_latency: res_valid per cycle %b required 1000", rv); end
      n_chk++; if (res_data !== 8'h84) begin n_fail++; $display("FAIL add_data: got %h required 84", res_data); end
      n_chk++; if (res_carry !== 1'b0) begin n_fail++; $display("FAIL add_carry: got %b required 0", res_carry); end
      n_chk++; if (res_rd !== 3'd3) begin n_fail++; $display("FAIL add_rd: got %0d required 3", res_rd); end
      tick();
      q.delete();
      read_reg(3'd3, d);
      n_chk++; if (d !== 8'h84) begin n_fail++; $display("FAIL add_rf3: got %h required 84", d); end
   endtask

   task test_sub_eq;
      logic got; res_t r;
      preload(3'd1, 8'hAC);
      preload(3'd2, 8'h17);
      issue(4'h1, 3'd5, 3'd1, 3'd2);
      wait_res(got, r);
      n_chk++; if (!got || r.data !== 8'h95 || r.carry !== 1'b1 || r.rd !== 3'd5) begin
         n_fail++; $display("FAIL sub: got=%b data %h carry %b rd %0d required 95/1/5", got, r.data, r.carry, r.rd);
      end
      issue(4'hC, 3'd6, 3'd5, 3'd5);
      wait_res(got, r);
      n_chk++; if (!got || r.data !== 8'h01 || r.rd !== 3'd6) begin
         n_fail++; $display("FAIL eq: got=%b data %h rd %0d required 01/6", got, r.data, r.rd);
      end
   endtask

   task test_dependency;
      logic got; res_t r;
      preload(3'd1, 8'h2B);
      preload(3'd2, 8'hA7);
      issue(4'h0, 3'd3, 3'd1, 3'd2);
      issue(4'h4, 3'd4, 3'd3, 3'd1);
      wait_res(got, r);
      n_chk++; if (!got || r.data !== 8'hD2 || r.rd !== 3'd3) begin
         n_fail++; $display("FAIL dep_first: got=%b data %h rd %0d required D2/3", got, r.data, r.rd);
      end
      wait_res(got, r);
      n_chk++; if (!got || r.data !== 8'hF9 || r.rd !== 3'd4) begin
         n_fail++; $display("FAIL dep_second: got=%b data %h rd %0d required F9/4", got, r.data, r.rd);
      end
   endtask

   task test_host_vs_wb;
      logic [7:0] d;
      preload(3'd1, 8'h33);
      for (int k = 0; k < 2; k++) begin
         issue(4'h0, (k == 0) ? 3'd5 : 3'd6, 3'd1, 3'd0);
         tick(); tick(); tick();
         wr_en = 1'b1; wr_addr = (k == 0) ? 3'd5 : 3'd4; wr_data = 8'hEE;
         @(negedge clk);
         n_chk++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL wb_window_%0d: res_valid %b required 1", k, res_valid); end
         tick();
         wr_en = 1'b0;
      end
      tick();
      q.delete();
      read_reg(3'd5, d);
      n_chk++; if (d !== 8'h33) begin n_fail++; $display("FAIL wb_wins: r5 got %h required 33", d); end
      read_reg(3'd6, d);
      n_chk++; if (d !== 8'h33) begin n_fail++; $display("FAIL wb_other: r6 got %h required 33", d); end
      read_reg(3'd4, d);
      n_chk++; if (d !== 8'hEE) begin n_fail++; $display("FAIL host_other: r4 got %h required EE", d); end
   endtask

   task test_backpressure;
      int acc, cyc, pend;
      logic saw_low, got;
      res_t r;
      preload(3'd1, 8'h10);
      q.delete();
      acc = 0; cyc = 0; saw_low = 1'b0; pend = -1;
      in_valid = 1'b1; in_op = 4'h0; in_rs1 = 3'd1; in_rs2 = 3'd0;
      while (acc < 8 && cyc < 200) begin
         in_rd = 3'(3 + acc % 4);
         @(negedge clk);
         if (in_ready) acc++;
         else if (!saw_low) begin saw_low = 1'b1; pend = acc - q.size(); end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      n_chk++; if (acc !== 8) begin n_fail++; $display("FAIL bp_accepted: got %0d required 8", acc); end
      n_chk++; if (saw_low !== 1'b1 || pend !== 4) begin
         n_fail++; $display("FAIL bp_ready_drop: saw_low %b pending %0d required 1/4", saw_low, pend);
      end
      for (int k = 0; k < 8; k++) begin
         wait_res(got, r);
         n_chk++; if (!got || r.rd !== 3'(3 + k % 4) || r.data !== 8'h10) begin
            n_fail++; $display("FAIL bp_result_%0d: got=%b rd %0d data %h required rd %0d data 10",
                               k, got, r.rd, r.data, 3 + k % 4);
         end
      end
      for (int k = 0; k < 10; k++) tick();
      n_chk++; if (q.size() !== 0) begin n_fail++; $display("FAIL bp_extra: %0d extra results required 0", q.size()); end
   endtask

   task test_reset_mid;
      logic [7:0] d;
      preload(3'd1, 8'h11);
      preload(3'd2, 8'h22);
      q.delete();
      issue(4'h0, 3'd5, 3'd1, 3'd2);
      issue(4'h0, 3'd6, 3'd1, 3'd2);
      issue(4'h0, 3'd3, 3'd1, 3'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_res_valid: got %b required 0", res_valid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
      for (int k = 0; k < 10; k++) tick();
      n_chk++; if (q.size() !== 0) begin n_fail++; $display("FAIL midrst_no_result: %0d results required 0", q.size()); end
      read_reg(3'd5, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL midrst_rd: r5 got %h required 00", d); end
   endtask

   task test_nop;
      logic [7:0] d;
      logic got; res_t r;
      preload(3'd1, 8'h0F);
      preload(3'd2, 8'h55);
      q.delete();
      issue(4'hD, 3'd2, 3'd1, 3'd1);
`ifdef NOP_SKIP_EN
      for (int k = 0; k < 10; k++) tick();
      n_chk++; if (q.size() !== 0) begin n_fail++; $display("FAIL nop_skip_result: %0d results required 0", q.size()); end
      read_reg(3'd2, d);
      n_chk++; if (d !== 8'h55) begin n_fail++; $display("FAIL nop_skip_rf: r2 got %h required 55", d); end
`else
      wait_res(got, r);
      n_chk++; if (!got || r.data !== 8'h00 || r.carry !== 1'b0 || r.rd !== 3'd2) begin
         n_fail++; $display("FAIL nop_result: got=%b data %h carry %b rd %0d required 00/0/2", got, r.data, r.carry, r.rd);
      end
      read_reg(3'd2, d);
      n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL nop_rf: r2 got %h required 00", d); end
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_eq();
      test_dependency();
      test_host_vs_wb();
      test_backpressure();
      test_reset_mid();
      test_nop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
